// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory request arbiter.
package mem_arb_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

    typedef enum logic [1:0] {
        OwnNone,
        OwnFetch,
        OwnLsb
    } owner_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b11;

    localparam logic [1:0] IO_TAG_DEFAULT = 2'b11;

endpackage

// File: rtl/mem_req_arbiter.sv
// Shares the byte-serial memory controller port between the instruction fetcher and the
// load/store buffer: LSB priority with a fetch anti-starvation streak limit.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned LSB_STREAK_MAX = 3,
    parameter logic [1:0]  IO_TAG         = IO_TAG_DEFAULT
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear_in,
    input  logic              io_buffer_full,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [31:0]       if_data,

    input  logic              ls_req,
    input  logic              ls_rnw,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_ready,
    output logic [31:0]       ls_rdata,

    output logic              mc_start,
    output logic              mc_rnw,
    output logic [1:0]        mc_size,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [31:0]       mc_wdata,
    input  logic              mc_done,
    input  logic [31:0]       mc_rdata
);

    localparam int unsigned STREAK_W =
        (LSB_STREAK_MAX > 0) ? $clog2(LSB_STREAK_MAX + 1) : 1;
    localparam logic [STREAK_W-1:0] STREAK_MAX_V = STREAK_W'(LSB_STREAK_MAX);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                squash_q, squash_d;

    logic                mc_start_q, mc_start_d;
    logic                mc_rnw_q, mc_rnw_d;
    logic [1:0]          mc_size_q, mc_size_d;
    logic [ADDR_W-1:0]   mc_addr_q, mc_addr_d;
    logic [31:0]         mc_wdata_q, mc_wdata_d;

    logic                if_ready_q, if_ready_d;
    logic                ls_ready_q, ls_ready_d;
    logic [31:0]         if_data_q, if_data_d;
    logic [31:0]         ls_rdata_q, ls_rdata_d;

    logic                ls_eligible;
    logic                if_eligible;
    logic                fetch_wins;
    logic                lsb_wins;

    // IO-region stores wait until the UART buffer has room.
    assign ls_eligible = ls_req &&
        !(!ls_rnw && (ls_addr[17:16] == IO_TAG) && io_buffer_full);
    assign if_eligible = if_req && !clear_in;
    assign fetch_wins  = if_eligible && (!ls_eligible || (streak_q == STREAK_MAX_V));
    assign lsb_wins    = ls_eligible && !fetch_wins;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        streak_d   = streak_q;
        squash_d   = squash_q;
        mc_start_d = 1'b0;
        mc_rnw_d   = mc_rnw_q;
        mc_size_d  = mc_size_q;
        mc_addr_d  = mc_addr_q;
        mc_wdata_d = mc_wdata_q;
        if_ready_d = 1'b0;
        ls_ready_d = 1'b0;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (fetch_wins) begin
                    mc_start_d = 1'b1;
                    mc_rnw_d   = 1'b1;
                    mc_size_d  = SZ_W;
                    mc_addr_d  = if_addr;
                    mc_wdata_d = 32'h0;
                    owner_d    = OwnFetch;
                    streak_d   = '0;
                    state_d    = StBusy;
                end else if (lsb_wins) begin
                    mc_start_d = 1'b1;
                    mc_rnw_d   = ls_rnw;
                    mc_size_d  = ls_size;
                    mc_addr_d  = ls_addr;
                    mc_wdata_d = ls_rnw ? 32'h0 : ls_wdata;
                    owner_d    = OwnLsb;
                    state_d    = StBusy;
                    // Streak only counts LSB grants that made a waiting fetch wait.
                    if (!if_req) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX_V) begin
                        streak_d = streak_q + 1'b1;
                    end
                end
            end
            StBusy: begin
                if (clear_in && (owner_q == OwnFetch)) begin
                    squash_d = 1'b1;
                end
                if (mc_done) begin
                    if (owner_q == OwnFetch) begin
                        if_data_d  = mc_rdata;
                        if_ready_d = !(squash_q || clear_in);
                    end else if (owner_q == OwnLsb) begin
                        ls_rdata_d = mc_rdata;
                        ls_ready_d = 1'b1;
                    end
                    squash_d = 1'b0;
                    owner_d  = OwnNone;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= StIdle;
            owner_q    <= OwnNone;
            streak_q   <= '0;
            squash_q   <= 1'b0;
            mc_start_q <= 1'b0;
            mc_rnw_q   <= 1'b0;
            mc_size_q  <= 2'b00;
            mc_addr_q  <= '0;
            mc_wdata_q <= 32'h0;
            if_ready_q <= 1'b0;
            ls_ready_q <= 1'b0;
            if_data_q  <= 32'h0;
            ls_rdata_q <= 32'h0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            streak_q   <= streak_d;
            squash_q   <= squash_d;
            mc_start_q <= mc_start_d;
            mc_rnw_q   <= mc_rnw_d;
            mc_size_q  <= mc_size_d;
            mc_addr_q  <= mc_addr_d;
            mc_wdata_q <= mc_wdata_d;
            if_ready_q <= if_ready_d;
            ls_ready_q <= ls_ready_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign mc_start = mc_start_q;
    assign mc_rnw   = mc_rnw_q;
    assign mc_size  = mc_size_q;
    assign mc_addr  = mc_addr_q;
    assign mc_wdata = mc_wdata_q;
    assign if_ready = if_ready_q;
    assign ls_ready = ls_ready_q;
    assign if_data  = if_data_q;
    assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed and randomized bench for mem_req_arbiter; the bench acts as controller and
// both requesters, with a transaction-level model of arbitration.
module tb_mem_req_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned AW  = 32;
    localparam int unsigned MAX = 3;

    logic          clk = 1'b0;
    logic          rst_in, rdy_in, clear_in, io_buffer_full;
    logic          if_req, ls_req, ls_rnw, mc_done;
    logic [AW-1:0] if_addr, ls_addr;
    logic [1:0]    ls_size;
    logic [31:0]   ls_wdata, mc_rdata;
    logic          if_ready, ls_ready, mc_start, mc_rnw;
    logic [31:0]   if_data, ls_rdata, mc_wdata;
    logic [1:0]    mc_size;
    logic [AW-1:0] mc_addr;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_req_arbiter #(
        .ADDR_W        (AW),
        .LSB_STREAK_MAX(MAX),
        .IO_TAG        (2'b11)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .clear_in      (clear_in),
        .io_buffer_full(io_buffer_full),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_ready      (if_ready),
        .if_data       (if_data),
        .ls_req        (ls_req),
        .ls_rnw        (ls_rnw),
        .ls_size       (ls_size),
        .ls_addr       (ls_addr),
        .ls_wdata      (ls_wdata),
        .ls_ready      (ls_ready),
        .ls_rdata      (ls_rdata),
        .mc_start      (mc_start),
        .mc_rnw        (mc_rnw),
        .mc_size       (mc_size),
        .mc_addr       (mc_addr),
        .mc_wdata      (mc_wdata),
        .mc_done       (mc_done),
        .mc_rdata      (mc_rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input string tag, input logic rnw, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata);
        check({tag, "_ctl"}, 64'({mc_start, mc_rnw, mc_size}), 64'({1'b1, rnw, size}));
        check({tag, "_aw"}, {mc_addr, mc_wdata}, {addr, wdata});
    endtask

    // Controller returns mc_done lat cycles after the visible start; ends on the ready cycle.
    task automatic complete(input int lat, input logic [31:0] rd);
        repeat (lat - 1) tick();
        mc_done  = 1'b1;
        mc_rdata = rd;
        tick();
        mc_done  = 1'b0;
        mc_rdata = 32'h0;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit            f_pend, l_pend, l_rnw, full, l_el, f_el, win_f;
        logic [31:0]   f_addr, l_addr, l_wdata, rd, exp_if_data, exp_ls_data;
        logic [1:0]    l_size;
        int            streak, lat;
        bit            seq[5];

        rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_rnw = 1'b0; ls_size = 2'b00;
        ls_addr = '0; ls_wdata = '0; mc_done = 1'b0; mc_rdata = '0;

        // Reset state
        do_reset();
        check("rst_ctl", 64'({mc_start, mc_rnw, mc_size, if_ready, ls_ready}), 64'(0));
        check("rst_aw", {mc_addr, mc_wdata}, 64'(0));
        check("rst_data", {if_data, ls_rdata}, 64'(0));

        // Fetch only
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        expect_grant("fetch_grant", 1'b1, SZ_W, 32'h100, 32'h0);
        tick();
        check("fetch_start_pulse", 64'(mc_start), 64'(0));
        repeat (3) tick();
        mc_done = 1'b1; mc_rdata = 32'h0000_0513;
        tick();
        mc_done = 1'b0;
        check("fetch_ready", 64'({if_ready, ls_ready}), 64'(2'b10));
        check("fetch_data", 64'(if_data), 64'(32'h0000_0513));
        if_req = 1'b0;
        tick();
        check("fetch_ready_pulse", 64'({if_ready, mc_start}), 64'(0));

        // Contention: expected L L L F L
        seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        if_req = 1'b1; if_addr = 32'h1000;
        ls_req = 1'b1; ls_rnw = 1'b1; ls_size = SZ_W; ls_addr = 32'h2000;
        ls_wdata = 32'hdead_beef;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (seq[i]) expect_grant($sformatf("cont%0d_f", i), 1'b1, SZ_W, if_addr, 32'h0);
            else        expect_grant($sformatf("cont%0d_l", i), 1'b1, SZ_W, ls_addr, 32'h0);
            complete(2, 32'h5000 + i);
            check($sformatf("cont%0d_rdy", i), 64'({if_ready, ls_ready}),
                  seq[i] ? 64'(2'b10) : 64'(2'b01));
            if (seq[i]) if_addr = if_addr + 4;
            else        ls_addr = ls_addr + 4;
        end
        if_req = 1'b0; ls_req = 1'b0;
        tick();

        // IO block
        ls_req = 1'b1; ls_rnw = 1'b0; ls_size = SZ_B; ls_addr = 32'h30000; ls_wdata = 32'h41;
        io_buffer_full = 1'b1; if_req = 1'b1; if_addr = 32'h200;
        tick();
        expect_grant("io_fetch", 1'b1, SZ_W, 32'h200, 32'h0);
        complete(3, 32'h1111);
        check("io_fetch_rdy", 64'({if_ready, ls_ready}), 64'(2'b10));
        if_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("io_blocked%0d", i), 64'(mc_start), 64'(0));
        end
        io_buffer_full = 1'b0;
        tick();
        expect_grant("io_store", 1'b0, SZ_B, 32'h30000, 32'h41);
        complete(2, 32'h0);
        check("io_store_rdy", 64'({if_ready, ls_ready}), 64'(2'b01));
        ls_req = 1'b0;
        tick();

        // Clear two cycles into a fetch
        if_req = 1'b1; if_addr = 32'h300;
        tick();
        expect_grant("clr_fetch", 1'b1, SZ_W, 32'h300, 32'h0);
        tick();
        clear_in = 1'b1; if_req = 1'b0;
        ls_req = 1'b1; ls_rnw = 1'b1; ls_size = SZ_H; ls_addr = 32'h400;
        tick();
        clear_in = 1'b0;
        complete(2, 32'h1234);
        check("clr_no_ready", 64'({if_ready, ls_ready}), 64'(0));
        tick();
        expect_grant("clr_ls_next", 1'b1, SZ_H, 32'h400, 32'h0);
        complete(1, 32'habcd);
        check("clr_ls_rdy", 64'({if_ready, ls_ready}), 64'(2'b01));
        check("clr_ls_data", 64'(ls_rdata), 64'(32'habcd));
        ls_req = 1'b0;

        // Clear coincident with mc_done
        if_req = 1'b1; if_addr = 32'h500;
        tick();
        expect_grant("clrdone_fetch", 1'b1, SZ_W, 32'h500, 32'h0);
        mc_done = 1'b1; clear_in = 1'b1; if_req = 1'b0;
        tick();
        mc_done = 1'b0; clear_in = 1'b0;
        check("clrdone_no_ready", 64'({if_ready, ls_ready}), 64'(0));

        // Freeze with rdy_in low while mc_start is high
        if_req = 1'b1; if_addr = 32'h600;
        tick();
        expect_grant("frz_grant", 1'b1, SZ_W, 32'h600, 32'h0);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_grant($sformatf("frz_hold%0d", i), 1'b1, SZ_W, 32'h600, 32'h0);
        end
        rdy_in = 1'b1;
        tick();
        check("frz_start_consumed", 64'(mc_start), 64'(0));
        complete(2, 32'h77);
        check("frz_ready", 64'({if_ready, ls_ready}), 64'(2'b10));
        check("frz_data", 64'(if_data), 64'(32'h77));
        if_req = 1'b0;

        // Reset mid-BUSY
        if_req = 1'b1; if_addr = 32'h700;
        tick();
        expect_grant("rstb_grant", 1'b1, SZ_W, 32'h700, 32'h0);
        tick();
        rst_in = 1'b1; if_req = 1'b0;
        tick();
        rst_in = 1'b0;
        check("rstb_ctl", 64'({mc_start, mc_rnw, mc_size, if_ready, ls_ready}), 64'(0));
        check("rstb_aw", {mc_addr, mc_wdata}, 64'(0));
        check("rstb_data", {if_data, ls_rdata}, 64'(0));
        mc_done = 1'b1; mc_rdata = 32'hffff_ffff;
        tick();
        mc_done = 1'b0;
        check("rstb_late_done0", 64'({if_ready, ls_ready, mc_start}), 64'(0));
        tick();
        check("rstb_late_done1", 64'({if_ready, ls_ready, mc_start}), 64'(0));

        // Randomized traffic against a transaction-level model
        do_reset();
        f_pend = 1'b0; l_pend = 1'b0; streak = 0;
        f_addr = '0; l_addr = '0; l_wdata = '0; l_rnw = 1'b0; l_size = SZ_B;
        exp_if_data = '0; exp_ls_data = '0;
        for (int it = 0; it < 60; it++) begin
            if (!f_pend && $urandom_range(0, 9) < 7) begin
                f_pend = 1'b1;
                f_addr = $urandom & 32'hffff_fffc;
            end
            if (!l_pend && $urandom_range(0, 9) < 7) begin
                l_pend  = 1'b1;
                l_rnw   = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 2))
                    0:       l_size = SZ_B;
                    1:       l_size = SZ_H;
                    default: l_size = SZ_W;
                endcase
                l_addr  = $urandom;
                if ($urandom_range(0, 3) == 0) l_addr[17:16] = 2'b11;
                l_wdata = $urandom;
            end
            full = ($urandom_range(0, 2) == 0);
            if_req = f_pend; if_addr = f_addr;
            ls_req = l_pend; ls_rnw = l_rnw; ls_size = l_size; ls_addr = l_addr;
            ls_wdata = l_wdata; io_buffer_full = full;

            l_el = l_pend && !(!l_rnw && (l_addr[17:16] == 2'b11) && full);
            f_el = f_pend;
            if (!l_el && !f_el) begin
                tick();
                check($sformatf("rnd%0d_idle", it), 64'(mc_start), 64'(0));
                continue;
            end
            win_f = f_el && (!l_el || streak == int'(MAX));
            tick();
            if (win_f) begin
                expect_grant($sformatf("rnd%0d_f", it), 1'b1, SZ_W, f_addr, 32'h0);
                streak = 0;
            end else begin
                expect_grant($sformatf("rnd%0d_l", it), l_rnw, l_size, l_addr,
                             l_rnw ? 32'h0 : l_wdata);
                streak = f_pend ? ((streak < int'(MAX)) ? streak + 1 : int'(MAX)) : 0;
            end
            lat = $urandom_range(1, 5);
            rd  = $urandom;
            complete(lat, rd);
            if (win_f) begin
                exp_if_data = rd;
                f_pend = 1'b0;
                if_req = 1'b0;
            end else begin
                exp_ls_data = rd;
                l_pend = 1'b0;
                ls_req = 1'b0;
            end
            check($sformatf("rnd%0d_rdy", it), 64'({if_ready, ls_ready}),
                  win_f ? 64'(2'b10) : 64'(2'b01));
            check($sformatf("rnd%0d_data", it), {if_data, ls_rdata}, {exp_if_data, exp_ls_data});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
